// File: rtl/board_sync_pkg.sv
// Shared defaults and helpers for the multi-channel board synchroniser.
// Lock/error logic is enabled by defining BOARD_SYNC_LOCK_EN.
package board_sync_pkg;

  localparam int unsigned DefaultNCh      = 4;
  localparam int unsigned DefaultCntWidth = 2;
  localparam int unsigned DefaultErrWidth = 8;
  localparam int unsigned DefaultLockCnt  = 4;
  localparam bit          DefaultOutInv   = 1'b1;

  // Match counters must hold LOCK_CNT up to 255.
  localparam int unsigned MatchWidth = 8;
  typedef logic [MatchWidth-1:0] match_cnt_t;

  function automatic int unsigned field_off(input int unsigned c, input int unsigned w);
    return c * w;
  endfunction

endpackage

// File: rtl/board_sync_mc_if.sv
// Per-channel bus bundle of board_sync_mc: pattern config, external syncs and status.
// The lock/error fields carry zeros unless BOARD_SYNC_LOCK_EN is defined.
interface board_sync_mc_if
  import board_sync_pkg::*;
#(
  parameter int unsigned N_CH      = DefaultNCh,
  parameter int unsigned CNT_WIDTH = DefaultCntWidth,
  parameter int unsigned ERR_WIDTH = DefaultErrWidth
);

  logic [N_CH-1:0]           synch_en;
  logic [N_CH*CNT_WIDTH-1:0] cnt_n;
  logic [N_CH*CNT_WIDTH-1:0] cnt_m;
  logic [N_CH-1:0]           sync_in;
  logic [N_CH-1:0]           sync_out;
  logic [N_CH-1:0]           status_int;
  logic [N_CH-1:0]           status_ext;
  logic [N_CH-1:0]           locked;
  logic [N_CH*ERR_WIDTH-1:0] err_cnt;

  modport master (
    output synch_en, cnt_n, cnt_m, sync_in,
    input  sync_out, status_int, status_ext, locked, err_cnt
  );

  modport slave (
    input  synch_en, cnt_n, cnt_m, sync_in,
    output sync_out, status_int, status_ext, locked, err_cnt
  );

endinterface

// File: rtl/board_sync_channel.sv
// One synchroniser channel: n-high-in-m pattern, sync_in re-timing, lock/error tracking.
// Lock/error logic is built only when BOARD_SYNC_LOCK_EN is defined.
module board_sync_channel
  import board_sync_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DefaultCntWidth,
  parameter int unsigned ERR_WIDTH = DefaultErrWidth,
  parameter int unsigned LOCK_CNT  = DefaultLockCnt,
  parameter bit          OUT_INV   = DefaultOutInv
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 e,
  input  logic                 phase_clr,
  input  logic                 err_clr,
  input  logic                 synch_en,
  input  logic [CNT_WIDTH-1:0] cnt_n,
  input  logic [CNT_WIDTH-1:0] cnt_m,
  input  logic                 sync_in,
  output logic                 sync_out,
  output logic                 status_int,
  output logic                 status_ext,
  output logic                 locked,
  output logic [ERR_WIDTH-1:0] err_cnt
);

  logic [CNT_WIDTH-1:0] ctr;
  logic                 synch;
  (* ASYNC_REG = "TRUE", IOB = "TRUE" *) logic sync_a;
  (* ASYNC_REG = "TRUE" *)               logic sync_b;

  // Set wins over clear when cnt_n == cnt_m; phase_clr wins over e.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr   <= '0;
      synch <= 1'b0;
    end else if (phase_clr) begin
      ctr   <= '0;
      synch <= 1'b0;
    end else if (e) begin
      ctr <= (ctr == cnt_m) ? '0 : ctr + 1'b1;
      if (!synch_en)          synch <= 1'b0;
      else if (ctr == cnt_m)  synch <= 1'b1;
      else if (ctr == cnt_n)  synch <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= sync_in;
      sync_b <= sync_a;
    end
  end

  // sync_out drives inverting buffers when OUT_INV is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_out   <= OUT_INV;
      status_int <= 1'b0;
      status_ext <= 1'b0;
    end else begin
      sync_out   <= synch ^ OUT_INV;
      status_int <= synch;
      status_ext <= sync_b;
    end
  end

`ifdef BOARD_SYNC_LOCK_EN
  localparam match_cnt_t LockMax = match_cnt_t'(LOCK_CNT);
  localparam match_cnt_t LockPre = match_cnt_t'(LOCK_CNT - 1);

  match_cnt_t match_cnt;
  logic       match;

  assign match = (sync_b == synch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
      locked    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (!synch_en) begin
        match_cnt <= '0;
        locked    <= 1'b0;
      end else if (e) begin
        if (match) begin
          if (match_cnt != LockMax) match_cnt <= match_cnt + 1'b1;
          if (match_cnt >= LockPre) locked <= 1'b1;
        end else begin
          match_cnt <= '0;
          locked    <= 1'b0;
        end
      end
      if (err_clr) begin
        err_cnt <= '0;
      end else if (e && synch_en && !match && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign locked         = 1'b0;
  assign err_cnt        = '0;
`endif

endmodule

// File: rtl/board_sync_mc.sv
// Multi-channel board synchroniser top: toggle re-timing, shared strobe, channel array.
// Define BOARD_SYNC_LOCK_EN to build the per-channel lock/error logic.
module board_sync_mc
  import board_sync_pkg::*;
#(
  parameter int unsigned N_CH      = DefaultNCh,
  parameter int unsigned CNT_WIDTH = DefaultCntWidth,
  parameter int unsigned ERR_WIDTH = DefaultErrWidth,
  parameter int unsigned LOCK_CNT  = DefaultLockCnt,
  parameter bit          OUT_INV   = DefaultOutInv
) (
  input logic            clk,
  input logic            rst_n,
  input logic            toggle_en,
  input logic            phase_clr,
  input logic            err_clr,
  board_sync_mc_if.slave bus
);

  (* ASYNC_REG = "TRUE" *) logic tog_a;
  (* ASYNC_REG = "TRUE" *) logic tog_b;
  logic e;

  // e is registered so it is high for exactly one cycle, one edge after the edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_a <= 1'b0;
      tog_b <= 1'b0;
      e     <= 1'b0;
    end else begin
      tog_a <= toggle_en;
      tog_b <= tog_a;
      e     <= tog_a & ~tog_b;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam int unsigned CntOff = field_off(c, CNT_WIDTH);
    localparam int unsigned ErrOff = field_off(c, ERR_WIDTH);

    board_sync_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .ERR_WIDTH (ERR_WIDTH),
      .LOCK_CNT  (LOCK_CNT),
      .OUT_INV   (OUT_INV)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .e          (e),
      .phase_clr  (phase_clr),
      .err_clr    (err_clr),
      .synch_en   (bus.synch_en[c]),
      .cnt_n      (bus.cnt_n[CntOff +: CNT_WIDTH]),
      .cnt_m      (bus.cnt_m[CntOff +: CNT_WIDTH]),
      .sync_in    (bus.sync_in[c]),
      .sync_out   (bus.sync_out[c]),
      .status_int (bus.status_int[c]),
      .status_ext (bus.status_ext[c]),
      .locked     (bus.locked[c]),
      .err_cnt    (bus.err_cnt[ErrOff +: ERR_WIDTH])
    );
  end

endmodule

// File: tb/tb_board_sync_mc.sv
// Scoreboard bench for board_sync_mc; lock/error expectations follow BOARD_SYNC_LOCK_EN.
module tb_board_sync_mc;
  import board_sync_pkg::*;

  localparam int unsigned N       = DefaultNCh;
  localparam int unsigned CW      = DefaultCntWidth;
  localparam int unsigned EW      = DefaultErrWidth;
  localparam int unsigned LockCnt = DefaultLockCnt;
  localparam bit          OutInv  = DefaultOutInv;
  localparam int          ErrMax  = (1 << EW) - 1;
`ifdef BOARD_SYNC_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0]    so;
    logic [N-1:0]    si;
    logic [N-1:0]    se;
    logic [N-1:0]    lk;
    logic [N*EW-1:0] err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, toggle_en, phase_clr, err_clr;
  logic loop_en;
  logic [N-1:0] force_mask, force_val;

  board_sync_mc_if #(.N_CH(N), .CNT_WIDTH(CW), .ERR_WIDTH(EW)) bus ();

  board_sync_mc #(
    .N_CH      (N),
    .CNT_WIDTH (CW),
    .ERR_WIDTH (EW),
    .LOCK_CNT  (LockCnt),
    .OUT_INV   (OutInv)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .toggle_en (toggle_en),
    .phase_clr (phase_clr),
    .err_clr   (err_clr),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // External loopback: the inverting buffer returns synch on sync_in.
  always_comb begin
    bus.sync_in = (force_mask & force_val) | (~force_mask & (loop_en ? ~bus.sync_out : '0));
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t scb[$];

  int           m_ctr [N];
  int           m_mc  [N];
  int           m_err [N];
  logic [N-1:0] m_synch;
  logic [N-1:0] m_lk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_ctr[c] = 0;
      m_mc[c]  = 0;
      m_err[c] = 0;
    end
    m_synch = '0;
    m_lk    = '0;
  endfunction

  function automatic logic ext_in(input int c);
    return force_mask[c] ? force_val[c] : (loop_en ? m_synch[c] : 1'b0);
  endfunction

  function automatic void model_step(input bit phase, input bit errclr);
    for (int c = 0; c < N; c++) begin
      int   cn, cm;
      logic en, inb;
      cn  = int'(bus.cnt_n[c*CW +: CW]);
      cm  = int'(bus.cnt_m[c*CW +: CW]);
      en  = bus.synch_en[c];
      inb = ext_in(c);
      if (LockEn) begin
        if (!en) begin
          m_mc[c] = 0;
          m_lk[c] = 1'b0;
        end else if (inb == m_synch[c]) begin
          if (m_mc[c] < int'(LockCnt)) m_mc[c]++;
          m_lk[c] = (m_mc[c] == int'(LockCnt));
        end else begin
          m_mc[c] = 0;
          m_lk[c] = 1'b0;
          if (!errclr && m_err[c] < ErrMax) m_err[c]++;
        end
        if (errclr) m_err[c] = 0;
      end
      if (phase) begin
        m_ctr[c]   = 0;
        m_synch[c] = 1'b0;
      end else begin
        if (!en)               m_synch[c] = 1'b0;
        else if (m_ctr[c] == cm) m_synch[c] = 1'b1;
        else if (m_ctr[c] == cn) m_synch[c] = 1'b0;
        m_ctr[c] = (m_ctr[c] == cm) ? 0 : (m_ctr[c] + 1) % (1 << CW);
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    x.so = m_synch ^ {N{OutInv}};
    x.si = m_synch;
    x.lk = m_lk;
    for (int c = 0; c < N; c++) begin
      x.se[c]             = ext_in(c);
      x.err[c*EW +: EW]   = EW'(m_err[c]);
    end
    return x;
  endfunction

  function automatic exp_t reset_exp();
    exp_t x;
    x     = '0;
    x.so  = {N{OutInv}};
    return x;
  endfunction

  task automatic check_outputs(input string tag, input exp_t x);
    check_eq({tag, ".sync_out"},   64'(bus.sync_out),   64'(x.so));
    check_eq({tag, ".status_int"}, 64'(bus.status_int), 64'(x.si));
    check_eq({tag, ".status_ext"}, 64'(bus.status_ext), 64'(x.se));
    check_eq({tag, ".locked"},     64'(bus.locked),     64'(x.lk));
    check_eq({tag, ".err_cnt"},    64'(bus.err_cnt),    64'(x.err));
  endtask

  // One toggle: toggle_en rises before edge k; sync_out must change at k+3, not k+2.
  task automatic do_toggle(input string tag, input bit phase, input bit errclr);
    exp_t prev, nxt;
    repeat (2) @(negedge clk);
    err_clr = errclr;
    prev = model_out();
    model_step(phase, errclr);
    nxt = model_out();
    scb.push_back(nxt);
    toggle_en = 1'b1;
    @(posedge clk);                       // k
    @(posedge clk);                       // k+1, e rises
    @(negedge clk);
    phase_clr = phase;
    @(posedge clk);                       // k+2, ctr/synch update
    #1 check_eq({tag, ".lat_k2"}, 64'(bus.sync_out), 64'(prev.so));
    @(negedge clk);
    phase_clr = 1'b0;
    toggle_en = 1'b0;
    @(posedge clk);                       // k+3
    #1 check_eq({tag, ".lat_k3"}, 64'(bus.sync_out), 64'(nxt.so));
    repeat (7) @(posedge clk);
    #1;
    if (scb.size() == 0) begin
      check_eq({tag, ".scb_empty"}, 64'(0), 64'(1));
    end else begin
      check_outputs(tag, scb.pop_front());
    end
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic set_cnt(input int n, input int m);
    bus.cnt_n = {N{CW'(n)}};
    bus.cnt_m = {N{CW'(m)}};
  endtask

  initial begin
    rst_n        = 1'b0;
    toggle_en    = 1'b0;
    phase_clr    = 1'b0;
    err_clr      = 1'b0;
    loop_en      = 1'b0;
    force_mask   = '0;
    force_val    = '0;
    bus.synch_en = '1;
    set_cnt(1, 3);
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_outputs("reset", reset_exp());
    @(negedge clk);
    rst_n = 1'b1;

    // Pattern: cnt_n=1, cnt_m=3, open sync inputs.
    for (int i = 0; i < 8; i++) do_toggle("pattern", 1'b0, 1'b0);

    // Loopback lock, then channel 2 input stuck low.
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    for (int c = 0; c < N; c++) m_err[c] = 0;
    loop_en = 1'b1;
    for (int i = 0; i < 6; i++) do_toggle("lock", 1'b0, 1'b0);
    force_mask = 4'b0100;
    force_val  = '0;
    for (int i = 0; i < 4; i++) do_toggle("ch2_stuck", 1'b0, 1'b0);
    force_mask = '0;

    // Set priority with cnt_n == cnt_m, then drop synch_en on channel 1.
    set_cnt(2, 2);
    for (int i = 0; i < 6; i++) do_toggle("set_prio", 1'b0, 1'b0);
    bus.synch_en = 4'b1101;
    for (int i = 0; i < 2; i++) do_toggle("en_drop", 1'b0, 1'b0);
    bus.synch_en = '1;

    // phase_clr coincident with e.
    set_cnt(1, 3);
    for (int i = 0; i < 3; i++) do_toggle("pre_phase", 1'b0, 1'b0);
    do_toggle("phase", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) do_toggle("post_phase", 1'b0, 1'b0);

    // Error saturation: synch held high, inputs forced low.
    loop_en    = 1'b0;
    force_mask = '1;
    force_val  = '0;
    set_cnt(0, 0);
    for (int i = 0; i < 300; i++) do_toggle("saturate", 1'b0, 1'b0);
    do_toggle("err_clr_mismatch", 1'b0, 1'b1);
    do_toggle("after_clr", 1'b0, 1'b0);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_outputs("async_reset", reset_exp());
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_toggle("post_reset", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
